// File: rtl/me_pkg.sv
// Shared definitions for the HEXBS motion-estimation frame scheduler:
// geometry defaults, result-record layout and scheduler state encoding.
package me_pkg;

  localparam int unsigned MB_SIZE    = 16;
  localparam int unsigned DEF_WIDTH  = 352;
  localparam int unsigned DEF_HEIGHT = 240;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned COORD_W = 32;
  localparam int unsigned MV_W   = 6;
  localparam int unsigned SAD_W  = 16;
  localparam int unsigned IDX_W  = 16;
  localparam int unsigned REC_W  = 32;
  localparam int unsigned STAT_W = 24;

  localparam int unsigned MV_X_MSB = 31;
  localparam int unsigned MV_X_LSB = 26;
  localparam int unsigned MV_Y_MSB = 25;
  localparam int unsigned MV_Y_LSB = 20;
  localparam int unsigned SAD_MSB  = 15;
  localparam int unsigned SAD_LSB  = 0;

  // One result-buffer word; field order matches the bit positions above.
  typedef struct packed {
    logic [MV_W-1:0]  mv_x;
    logic [MV_W-1:0]  mv_y;
    logic [3:0]       rsvd;
    logic [SAD_W-1:0] sad;
  } me_record_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    WRITE,
    RELEASE,
    NEXT,
    FINISH
  } sched_state_e;

  function automatic logic [REC_W-1:0] pack_record(
    input logic [MV_W-1:0]  mv_x,
    input logic [MV_W-1:0]  mv_y,
    input logic [SAD_W-1:0] sad
  );
    me_record_t rec;
    rec.mv_x = mv_x;
    rec.mv_y = mv_y;
    rec.rsvd = 4'h0;
    rec.sad  = sad;
    return REC_W'(rec);
  endfunction

endpackage

// File: rtl/me_mb_raster_cnt.sv
// Raster-order macroblock position counter (pixel x/y plus linear index)
// with a combinational flag marking the final macroblock of the frame.
module me_mb_raster_cnt
  import me_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                advance,
  output logic [COORD_W-1:0]  mb_x,
  output logic [COORD_W-1:0]  mb_y,
  output logic [IDX_W-1:0]    mb_idx,
  output logic                last_c
);

  localparam int unsigned X_LAST = WIDTH - MB_SIZE;
  localparam int unsigned Y_LAST = HEIGHT - MB_SIZE;

  logic row_end_c;

  assign row_end_c = (mb_x == COORD_W'(X_LAST));
  assign last_c    = row_end_c && (mb_y == COORD_W'(Y_LAST));

  // Position advances only between macroblocks, so it is stable while the core runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_x   <= '0;
      mb_y   <= '0;
      mb_idx <= '0;
    end else if (clear) begin
      mb_x   <= '0;
      mb_y   <= '0;
      mb_idx <= '0;
    end else if (advance) begin
      if (row_end_c) begin
        mb_x <= '0;
        mb_y <= mb_y + COORD_W'(MB_SIZE);
      end else begin
        mb_x <= mb_x + COORD_W'(MB_SIZE);
      end
      mb_idx <= mb_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/me_frame_sched.sv
// Frame-level macroblock scheduler driving the HEXBS ME core handshake and
// writing one packed MV/SAD record per macroblock. Optional SAD statistics
// are built when ME_SAD_STATS_EN is defined.
module me_frame_sched
  import me_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned HEIGHT   = DEF_HEIGHT,
  parameter int unsigned RES_BASE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [ADDR_W-1:0]   cur_frame_addr,
  input  logic [ADDR_W-1:0]   ref_frame_addr,
  output logic                busy,
  output logic                frame_done,
  output logic                me_start,
  output logic [ADDR_W-1:0]   me_frame_addr,
  output logic [ADDR_W-1:0]   me_ref_addr,
  output logic [COORD_W-1:0]  me_mb_x,
  output logic [COORD_W-1:0]  me_mb_y,
  input  logic [MV_W-1:0]     me_mv_x,
  input  logic [MV_W-1:0]     me_mv_y,
  input  logic [SAD_W-1:0]    me_sad,
  input  logic                me_done,
  output logic                res_we,
  output logic [IDX_W-1:0]    res_addr,
  output logic [REC_W-1:0]    res_wdata,
  output logic [STAT_W-1:0]   sad_total,
  output logic [SAD_W-1:0]    sad_max
);

  sched_state_e state_q, state_d;

  logic             accept_c;
  logic             capture_c;
  logic             advance_c;
  logic             last_c;
  logic             busy_d;
  logic             me_start_d;
  logic             res_we_d;
  logic             frame_done_d;
  logic [IDX_W-1:0] mb_idx;

  me_mb_raster_cnt #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept_c),
    .advance (advance_c),
    .mb_x    (me_mb_x),
    .mb_y    (me_mb_y),
    .mb_idx  (mb_idx),
    .last_c  (last_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Output next-values key off the next state so each strobe lines up with its state.
  always_comb begin
    state_d      = state_q;
    accept_c     = 1'b0;
    capture_c    = 1'b0;
    advance_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          accept_c = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (me_done) begin
          capture_c = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE:     state_d = RELEASE;
      RELEASE:   if (!me_done) state_d = NEXT;
      NEXT: begin
        advance_c = 1'b1;
        state_d   = last_c ? FINISH : ISSUE;
      end
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    busy_d       = (state_q != IDLE) && (state_d != IDLE) && (state_d != FINISH);
    me_start_d   = (state_d == WAIT_DONE);
    res_we_d     = capture_c;
    frame_done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      me_start      <= 1'b0;
      res_we        <= 1'b0;
      me_frame_addr <= '0;
      me_ref_addr   <= '0;
      res_addr      <= '0;
      res_wdata     <= '0;
    end else begin
      busy       <= busy_d;
      frame_done <= frame_done_d;
      me_start   <= me_start_d;
      res_we     <= res_we_d;
      if (accept_c) begin
        me_frame_addr <= cur_frame_addr;
        me_ref_addr   <= ref_frame_addr;
      end
      if (capture_c) begin
        res_addr  <= IDX_W'(RES_BASE) + mb_idx;
        res_wdata <= pack_record(me_mv_x, me_mv_y, me_sad);
      end
    end
  end

`ifdef ME_SAD_STATS_EN
  localparam int unsigned SUM_W = STAT_W + 1;

  logic [STAT_W-1:0] sad_total_q;
  logic [SAD_W-1:0]  sad_max_q;
  logic [SUM_W-1:0]  sum_c;

  assign sum_c = {1'b0, sad_total_q} + SUM_W'(me_sad);

  // Running frame statistics; the sum saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad_total_q <= '0;
      sad_max_q   <= '0;
    end else if (accept_c) begin
      sad_total_q <= '0;
      sad_max_q   <= '0;
    end else if (capture_c) begin
      sad_total_q <= sum_c[STAT_W] ? {STAT_W{1'b1}} : sum_c[STAT_W-1:0];
      if (me_sad > sad_max_q) sad_max_q <= me_sad;
    end
  end

  assign sad_total = sad_total_q;
  assign sad_max   = sad_max_q;
`else
  assign sad_total = '0;
  assign sad_max   = '0;
`endif

endmodule

// File: tb/tb_me_frame_sched.sv
// Self-checking bench for me_frame_sched: randomized ME core model plus a
// frame-level reference of the expected raster walk and result records.
module tb_me_frame_sched;

  localparam int unsigned W   = 352;
  localparam int unsigned H   = 240;
  localparam int unsigned RB  = 256;
  localparam int unsigned NX  = W / 16;
  localparam int unsigned NMB = (W / 16) * (H / 16);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [31:0] cur_frame_addr, ref_frame_addr;
  logic        busy, frame_done, me_start;
  logic [31:0] me_frame_addr, me_ref_addr, me_mb_x, me_mb_y;
  logic [5:0]  me_mv_x, me_mv_y;
  logic [15:0] me_sad;
  logic        me_done;
  logic        res_we;
  logic [15:0] res_addr;
  logic [31:0] res_wdata;
  logic [23:0] sad_total;
  logic [15:0] sad_max;

  me_frame_sched #(.WIDTH(W), .HEIGHT(H), .RES_BASE(RB)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .cur_frame_addr(cur_frame_addr), .ref_frame_addr(ref_frame_addr),
    .busy(busy), .frame_done(frame_done), .me_start(me_start),
    .me_frame_addr(me_frame_addr), .me_ref_addr(me_ref_addr),
    .me_mb_x(me_mb_x), .me_mb_y(me_mb_y),
    .me_mv_x(me_mv_x), .me_mv_y(me_mv_y), .me_sad(me_sad), .me_done(me_done),
    .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata),
    .sad_total(sad_total), .sad_max(sad_max)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_q[$];
  int          wr_cnt, issue_cnt, fd_cnt;
  int          lat, cnt, hold, extra_hold;
  bit          sad_ff_mode;
  logic        prev_start;
  logic [31:0] exp_cur, exp_ref;
  longint      exp_sum;
  int          exp_max;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: monitor DUT outputs, then advance the ME core model.
  task automatic step();
    logic [5:0]  mvx, mvy;
    logic [15:0] sad;
    @(negedge clk);
    if (res_we) begin
      chk("res_addr", 32'(res_addr), RB + wr_cnt);
      chk("write_mb_x", me_mb_x, (wr_cnt % NX) * 16);
      chk("write_mb_y", me_mb_y, (wr_cnt / NX) * 16);
      chk("start_low_at_write", 32'(me_start), 32'd0);
      if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else                   chk("res_wdata", res_wdata, exp_q.pop_front());
      wr_cnt++;
    end
    if (me_start && !prev_start) begin
      chk("start_gap_done_low", 32'(me_done), 32'd0);
      chk("issue_mb_x", me_mb_x, (issue_cnt % NX) * 16);
      chk("issue_mb_y", me_mb_y, (issue_cnt / NX) * 16);
      chk("issue_cur_addr", me_frame_addr, exp_cur);
      chk("issue_ref_addr", me_ref_addr, exp_ref);
      issue_cnt++;
    end
    if (frame_done) begin
      fd_cnt++;
      chk("busy_low_at_done", 32'(busy), 32'd0);
      chk("writes_at_done", wr_cnt, NMB);
    end
    prev_start = me_start;
    if (!me_done) begin
      if (me_start) begin
        cnt++;
        if (cnt >= lat) begin
          mvx = 6'($urandom);
          mvy = 6'($urandom);
          sad = sad_ff_mode ? 16'hFFFF : 16'($urandom);
          me_mv_x = mvx;
          me_mv_y = mvy;
          me_sad  = sad;
          me_done = 1'b1;
          exp_q.push_back({mvx, mvy, 4'h0, sad});
          exp_sum += longint'(sad);
          if (int'(sad) > exp_max) exp_max = int'(sad);
          cnt = 0;
        end
      end
    end else if (!me_start) begin
      if (hold >= extra_hold) begin
        me_done = 1'b0;
        hold = 0;
        lat = $urandom_range(1, 6);
      end else begin
        hold++;
      end
    end
  endtask

  task automatic begin_frame(input logic [31:0] cur, input logic [31:0] ref_a,
                             input int extra, input bit sad_ff);
    exp_cur = cur; exp_ref = ref_a; extra_hold = extra; sad_ff_mode = sad_ff;
    wr_cnt = 0; issue_cnt = 0; fd_cnt = 0; exp_sum = 0; exp_max = 0;
    exp_q.delete();
    cur_frame_addr = cur; ref_frame_addr = ref_a; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("busy_one_after_start", 32'(busy), 32'd0);
    chk("start_one_after_start", 32'(me_start), 32'd0);
    step();
    chk("busy_two_after_start", 32'(busy), 32'd1);
    chk("start_two_after_start", 32'(me_start), 32'd1);
  endtask

  task automatic finish_frame(input bit mid_start);
    bit          pulsed;
    logic [31:0] etot, emax;
    pulsed = 1'b0;
    for (int i = 0; i < 30000 && fd_cnt == 0; i++) begin
      if (mid_start && !pulsed && wr_cnt == 7) begin
        cur_frame_addr = ~exp_cur;
        ref_frame_addr = ~exp_ref;
        frame_start = 1'b1;
        pulsed = 1'b1;
        step();
        frame_start = 1'b0;
        chk("busy_during_ignored_start", 32'(busy), 32'd1);
      end else begin
        step();
      end
    end
    if (fd_cnt == 0) chk("frame_timeout", 32'd0, 32'd1);
    repeat (3) step();
    chk("frame_done_pulses", fd_cnt, 1);
    chk("total_writes", wr_cnt, NMB);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("final_res_addr", 32'(res_addr), RB + NMB - 1);
    chk("latched_cur_after_frame", me_frame_addr, exp_cur);
`ifdef ME_SAD_STATS_EN
    etot = (exp_sum > 64'hFFFFFF) ? 32'hFFFFFF : 32'(exp_sum);
    emax = 32'(exp_max);
`else
    etot = 32'd0;
    emax = 32'd0;
`endif
    chk("sad_total", 32'(sad_total), etot);
    chk("sad_max", 32'(sad_max), emax);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_me_start"}, 32'(me_start), 32'd0);
    chk({tag, "_res_we"}, 32'(res_we), 32'd0);
    chk({tag, "_res_addr"}, 32'(res_addr), 32'd0);
    chk({tag, "_res_wdata"}, res_wdata, 32'd0);
    chk({tag, "_frame_addr"}, me_frame_addr, 32'd0);
    chk({tag, "_ref_addr"}, me_ref_addr, 32'd0);
    chk({tag, "_mb_x"}, me_mb_x, 32'd0);
    chk({tag, "_mb_y"}, me_mb_y, 32'd0);
    chk({tag, "_sad_total"}, 32'(sad_total), 32'd0);
    chk({tag, "_sad_max"}, 32'(sad_max), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0;
    cur_frame_addr = '0; ref_frame_addr = '0;
    me_done = 1'b0; me_mv_x = '0; me_mv_y = '0; me_sad = '0;
    prev_start = 1'b0; lat = 3; cnt = 0; hold = 0; extra_hold = 0;
    sad_ff_mode = 1'b0; exp_sum = 0; exp_max = 0;
    wr_cnt = 0; issue_cnt = 0; fd_cnt = 0; exp_cur = '0; exp_ref = '0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) step();

    begin_frame($urandom, $urandom, 0, 1'b0);
    finish_frame(1'b0);

    // Core holds done after start falls; a stray start mid-frame is ignored.
    begin_frame($urandom, $urandom, 3, 1'b0);
    finish_frame(1'b1);

    // Abort while the core is working, then restart from macroblock 0.
    begin_frame($urandom, $urandom, 0, 1'b0);
    for (int i = 0; i < 2000 && !(wr_cnt >= 3 && me_start && !me_done); i++) step();
    chk("reached_wait_done", 32'(me_start && !me_done), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    me_done = 1'b0; cnt = 0; hold = 0; prev_start = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    repeat (2) step();
    begin_frame($urandom, $urandom, 0, 1'b0);
    finish_frame(1'b0);

    // Maximum SAD on every macroblock drives the frame sum into saturation.
    begin_frame($urandom, $urandom, 1, 1'b1);
    finish_frame(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
